// File: rtl/risc_pkg.sv
// rtl/risc_pkg.sv - shared opcode constants and fetch-stage state encoding
package risc_pkg;

    localparam logic [3:0]  OP_NOP     = 4'h0;
    localparam logic [3:0]  HLT_OPCODE = 4'hF;
    localparam logic [15:0] NOP_INSTR  = 16'h0000;
    localparam logic [15:0] RESET_PC   = 16'h0000;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        HALT_PEND = 2'd1,
        HALTED    = 2'd2
    } fetch_state_t;

    function automatic logic is_opcode(input logic [15:0] instr, input logic [3:0] op);
        return instr[15:12] == op;
    endfunction

endpackage

// File: rtl/CLA_16bit.sv
// rtl/CLA_16bit.sv - 16-bit carry-lookahead adder/subtractor, 4-bit groups, no carry out
module CLA_16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        sub,
    output logic [15:0] sum
);

    logic [15:0] bx, g, p, c;
    logic [2:0]  gg, pg;
    logic [3:0]  cg;

    assign bx = b ^ {16{sub}};
    assign g  = a & bx;
    assign p  = a ^ bx;

    always_comb begin
        gg = '0;
        pg = '0;
        for (int k = 0; k < 3; k++) begin
            gg[k] = g[4*k+3]
                  | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            pg[k] = &p[4*k +: 4];
        end
    end

    // Second-level lookahead: carry into each 4-bit group
    assign cg[0] = sub;
    assign cg[1] = gg[0] | (pg[0] & sub);
    assign cg[2] = gg[1] | (pg[1] & gg[0]) | (pg[1] & pg[0] & sub);
    assign cg[3] = gg[2] | (pg[2] & gg[1]) | (pg[2] & pg[1] & gg[0])
                 | (pg[2] & pg[1] & pg[0] & sub);

    always_comb begin
        c = '0;
        for (int k = 0; k < 4; k++) begin
            c[4*k]   = cg[k];
            c[4*k+1] = g[4*k] | (p[4*k] & cg[k]);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & cg[k]);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
                     | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & cg[k]);
        end
    end

    assign sum = p ^ c;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch: PC, IF/ID register, branch flush and HLT drain
module fetch_stage
    import risc_pkg::*;
#(
    parameter logic [15:0] RESET_PC_P   = RESET_PC,
    parameter logic [15:0] NOP_INSTR_P  = NOP_INSTR,
    parameter logic [3:0]  HLT_OPCODE_P = HLT_OPCODE,
    parameter int          DRAIN_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    output logic [15:0] pc_current,
    output logic [15:0] ifid_instr,
    output logic [15:0] ifid_pc_plus2,
    output logic        ifid_valid,
    output logic        halted
);

    localparam int CW = $clog2(DRAIN_CYCLES + 1);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_CYCLES - 1);

    fetch_state_t  state;
    logic [15:0]   pc;
    logic [15:0]   pc_plus2;
    logic [CW-1:0] drain_cnt;

    CLA_16bit u_pc_add (
        .a   (pc),
        .b   (16'h0002),
        .sub (1'b0),
        .sum (pc_plus2)
    );

    assign imem_addr  = pc;
    assign pc_current = pc;

    // ifid_pc_plus2 is left untouched on bubbles; consumers qualify it with ifid_valid
    always_ff @(posedge clk) begin
        if (rst) begin
            pc            <= RESET_PC_P;
            ifid_instr    <= NOP_INSTR_P;
            ifid_pc_plus2 <= 16'h0000;
            ifid_valid    <= 1'b0;
            state         <= RUN;
            drain_cnt     <= '0;
            halted        <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (branch_taken) begin
                        pc         <= branch_target;
                        ifid_instr <= NOP_INSTR_P;
                        ifid_valid <= 1'b0;
                    end else if (!stall) begin
                        ifid_instr    <= imem_data;
                        ifid_pc_plus2 <= pc_plus2;
                        ifid_valid    <= 1'b1;
                        if (is_opcode(imem_data, HLT_OPCODE_P)) begin
                            state     <= HALT_PEND;
                            drain_cnt <= '0;
                        end else begin
                            pc <= pc_plus2;
                        end
                    end
                end
                HALT_PEND: begin
                    if (branch_taken) begin
                        // A branch older than the HLT wins and cancels the halt
                        pc         <= branch_target;
                        ifid_instr <= NOP_INSTR_P;
                        ifid_valid <= 1'b0;
                        state      <= RUN;
                        drain_cnt  <= '0;
                    end else if (!stall) begin
                        ifid_instr <= NOP_INSTR_P;
                        ifid_valid <= 1'b0;
                        drain_cnt  <= drain_cnt + 1'b1;
                        if (drain_cnt == DRAIN_LAST) begin
                            state  <= HALTED;
                            halted <= 1'b1;
                        end
                    end
                end
                HALTED: begin
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed scoreboard bench for fetch_stage
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst, stall, branch_taken;
    logic [15:0] branch_target, imem_addr, imem_data, pc_current;
    logic [15:0] ifid_instr, ifid_pc_plus2;
    logic        ifid_valid, halted;

    logic [15:0] mem [0:65535];

    typedef struct {
        logic [15:0] pc;
        logic [15:0] instr;
        logic [15:0] pp2;
        logic        v;
        logic        h;
        logic        chk_pp2;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   step  = 0;

    always #5 clk = ~clk;

    assign imem_data = mem[imem_addr];

    fetch_stage dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .pc_current    (pc_current),
        .ifid_instr    (ifid_instr),
        .ifid_pc_plus2 (ifid_pc_plus2),
        .ifid_valid    (ifid_valid),
        .halted        (halted)
    );

    task automatic chk(input string name, input int n, input logic [15:0] act, input logic [15:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL step %0d %s: got %h expected %h", n, name, act, exp_v);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            while (q.size() > 0) begin
                e = q.pop_front();
                chk("pc_current", step, pc_current, e.pc);
                chk("imem_addr", step, imem_addr, e.pc);
                chk("ifid_instr", step, ifid_instr, e.instr);
                chk("ifid_valid", step, {15'd0, ifid_valid}, {15'd0, e.v});
                chk("halted", step, {15'd0, halted}, {15'd0, e.h});
                if (e.chk_pp2) chk("ifid_pc_plus2", step, ifid_pc_plus2, e.pp2);
            end
        end
    end

    // Drive one cycle of inputs, then queue the outputs expected after that edge
    task automatic cyc(input logic r, input logic br, input logic [15:0] tgt, input logic st,
                       input logic [15:0] e_pc, input logic [15:0] e_instr,
                       input logic [15:0] e_pp2, input logic e_v, input logic e_h);
        exp_t e;
        rst = r; branch_taken = br; branch_target = tgt; stall = st;
        @(posedge clk);
        step++;
        e.pc = e_pc; e.instr = e_instr; e.pp2 = e_pp2; e.v = e_v; e.h = e_h;
        e.chk_pp2 = e_v | r;
        q.push_back(e);
        @(negedge clk);
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = {4'h1, 12'(a)};
        mem[16'h0000] = 16'h1234;
        mem[16'h0020] = 16'hF000;
        mem[16'h0030] = 16'hF000;

        //    rst br tgt       st  pc        instr     pp2       v  h
        cyc(1, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0);
        cyc(1, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0);
        cyc(0, 0, 16'h0000, 0, 16'h0002, 16'h1234, 16'h0002, 1, 0);
        cyc(0, 0, 16'h0000, 0, 16'h0004, 16'h1002, 16'h0004, 1, 0);
        cyc(0, 0, 16'h0000, 0, 16'h0006, 16'h1004, 16'h0006, 1, 0);
        cyc(0, 0, 16'h0000, 1, 16'h0006, 16'h1004, 16'h0006, 1, 0);
        cyc(0, 0, 16'h0000, 1, 16'h0006, 16'h1004, 16'h0006, 1, 0);
        cyc(0, 0, 16'h0000, 0, 16'h0008, 16'h1006, 16'h0008, 1, 0);
        // branch flush, alone and with simultaneous stall
        cyc(0, 1, 16'h0010, 0, 16'h0010, 16'h0000, 16'h0000, 0, 0);
        cyc(0, 1, 16'h0040, 0, 16'h0040, 16'h0000, 16'h0000, 0, 0);
        cyc(0, 0, 16'h0000, 0, 16'h0042, 16'h1040, 16'h0042, 1, 0);
        cyc(0, 1, 16'h0010, 1, 16'h0010, 16'h0000, 16'h0000, 0, 0);
        cyc(0, 0, 16'h0000, 0, 16'h0012, 16'h1010, 16'h0012, 1, 0);
        cyc(0, 1, 16'h0020, 1, 16'h0020, 16'h0000, 16'h0000, 0, 0);
        // HLT at 0x20, drain with one stall inserted
        cyc(0, 0, 16'h0000, 0, 16'h0020, 16'hF000, 16'h0022, 1, 0);
        cyc(0, 0, 16'h0000, 0, 16'h0020, 16'h0000, 16'h0000, 0, 0);
        cyc(0, 0, 16'h0000, 1, 16'h0020, 16'h0000, 16'h0000, 0, 0);
        cyc(0, 0, 16'h0000, 0, 16'h0020, 16'h0000, 16'h0000, 0, 0);
        cyc(0, 0, 16'h0000, 0, 16'h0020, 16'h0000, 16'h0000, 0, 0);
        cyc(0, 0, 16'h0000, 0, 16'h0020, 16'h0000, 16'h0000, 0, 1);
        cyc(0, 1, 16'h0100, 0, 16'h0020, 16'h0000, 16'h0000, 0, 1);
        cyc(0, 0, 16'h0000, 1, 16'h0020, 16'h0000, 16'h0000, 0, 1);
        cyc(0, 0, 16'h0000, 0, 16'h0020, 16'h0000, 16'h0000, 0, 1);
        cyc(1, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0);
        // HLT cancelled by branch during drain
        cyc(0, 1, 16'h0030, 0, 16'h0030, 16'h0000, 16'h0000, 0, 0);
        cyc(0, 0, 16'h0000, 0, 16'h0030, 16'hF000, 16'h0032, 1, 0);
        cyc(0, 0, 16'h0000, 0, 16'h0030, 16'h0000, 16'h0000, 0, 0);
        cyc(0, 1, 16'h0100, 0, 16'h0100, 16'h0000, 16'h0000, 0, 0);
        cyc(0, 0, 16'h0000, 0, 16'h0102, 16'h1100, 16'h0102, 1, 0);
        cyc(0, 0, 16'h0000, 0, 16'h0104, 16'h1102, 16'h0104, 1, 0);
        cyc(0, 0, 16'h0000, 0, 16'h0106, 16'h1104, 16'h0106, 1, 0);
        cyc(0, 0, 16'h0000, 0, 16'h0108, 16'h1106, 16'h0108, 1, 0);
        cyc(0, 0, 16'h0000, 0, 16'h010A, 16'h1108, 16'h010A, 1, 0);
        // PC wrap at 0xFFFE
        cyc(0, 1, 16'hFFFE, 0, 16'hFFFE, 16'h0000, 16'h0000, 0, 0);
        cyc(0, 0, 16'h0000, 0, 16'h0000, 16'h1FFE, 16'h0000, 1, 0);
        cyc(0, 0, 16'h0000, 0, 16'h0002, 16'h1234, 16'h0002, 1, 0);
        // reset in the middle of a drain
        cyc(0, 1, 16'h0020, 0, 16'h0020, 16'h0000, 16'h0000, 0, 0);
        cyc(0, 0, 16'h0000, 0, 16'h0020, 16'hF000, 16'h0022, 1, 0);
        cyc(0, 0, 16'h0000, 0, 16'h0020, 16'h0000, 16'h0000, 0, 0);
        cyc(1, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0);
        cyc(0, 0, 16'h0000, 0, 16'h0002, 16'h1234, 16'h0002, 1, 0);
        cyc(0, 0, 16'h0000, 0, 16'h0004, 16'h1002, 16'h0004, 1, 0);

        @(negedge clk);
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
